// File: rtl/fpga_pkg.sv
// Shared types for the FPGA shell's axi_lite control bus and register map.
// The axi_lite request/response structs are the shell-wide bus typedefs; the
// register map adds offsets, a decoded-index enum and the two FSM state enums.
package fpga_pkg;

  localparam int LITE_ADDR_W = 13;
  localparam int LITE_DATA_W = 32;
  localparam int LITE_STRB_W = LITE_DATA_W / 8;
  localparam int LITE_IDX_W  = LITE_ADDR_W - 2;

  // Byte offsets of the register map
  localparam logic [LITE_ADDR_W-1:0] LITE_REG_ID       = 13'h000;
  localparam logic [LITE_ADDR_W-1:0] LITE_REG_SCRATCH  = 13'h004;
  localparam logic [LITE_ADDR_W-1:0] LITE_REG_CTRL     = 13'h008;
  localparam logic [LITE_ADDR_W-1:0] LITE_REG_STATUS   = 13'h00C;
  localparam logic [LITE_ADDR_W-1:0] LITE_REG_CORE_RST = 13'h010;
  localparam logic [LITE_ADDR_W-1:0] LITE_REG_CYCLE_LO = 13'h014;
  localparam logic [LITE_ADDR_W-1:0] LITE_REG_CYCLE_HI = 13'h018;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // axi_lite bus typedefs
  typedef struct packed {
    logic [LITE_ADDR_W-1:0] addr;
    logic [2:0]             prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [LITE_DATA_W-1:0] data;
    logic [LITE_STRB_W-1:0] strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [LITE_DATA_W-1:0] data;
    logic [1:0]             resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         w_ready;
    axi_lite_b_t  b;
    logic         b_valid;
    logic         ar_ready;
    axi_lite_r_t  r;
    logic         r_valid;
  } axi_lite_resp_t;

  // Decoded register index; LITE_IDX_NONE marks an unmapped address
  typedef enum logic [2:0] {
    LITE_IDX_ID,
    LITE_IDX_SCRATCH,
    LITE_IDX_CTRL,
    LITE_IDX_STATUS,
    LITE_IDX_CORE_RST,
    LITE_IDX_CYCLE_LO,
    LITE_IDX_CYCLE_HI,
    LITE_IDX_NONE
  } lite_reg_e;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  // Word index (addr[12:2]) to register; byte lanes are ignored
  function automatic lite_reg_e lite_decode(input logic [LITE_IDX_W-1:0] idx);
    lite_reg_e reg_e;
    case ({idx, 2'b00})
      LITE_REG_ID:       reg_e = LITE_IDX_ID;
      LITE_REG_SCRATCH:  reg_e = LITE_IDX_SCRATCH;
      LITE_REG_CTRL:     reg_e = LITE_IDX_CTRL;
      LITE_REG_STATUS:   reg_e = LITE_IDX_STATUS;
      LITE_REG_CORE_RST: reg_e = LITE_IDX_CORE_RST;
      LITE_REG_CYCLE_LO: reg_e = LITE_IDX_CYCLE_LO;
      LITE_REG_CYCLE_HI: reg_e = LITE_IDX_CYCLE_HI;
      default:           reg_e = LITE_IDX_NONE;
    endcase
    return reg_e;
  endfunction

  // Merge new data into old under a byte strobe
  function automatic logic [LITE_DATA_W-1:0] lite_apply_strb(
    input logic [LITE_DATA_W-1:0] old_data,
    input logic [LITE_DATA_W-1:0] new_data,
    input logic [LITE_STRB_W-1:0] strb
  );
    logic [LITE_DATA_W-1:0] res;
    res = old_data;
    for (int b = 0; b < LITE_STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fpga_axi_lite_regfile.sv
// Register storage for the shell control/status map: byte-strobed writes,
// combinational read mux, free-running 64-bit cycle counter and the HI shadow
// that keeps a CYCLE_LO-then-CYCLE_HI read pair coherent.
module fpga_axi_lite_regfile
  import fpga_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = 32'h5A47_0001,
  parameter logic [31:0] CTRL_RST  = 32'h0,
  parameter logic [63:0] CYCLE_RST = 64'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           i_status,
  input  logic                  i_wr_en,
  input  logic [LITE_IDX_W-1:0] i_wr_idx,
  input  logic [31:0]           i_wr_data,
  input  logic [3:0]            i_wr_strb,
  input  logic                  i_rd_en,
  input  logic [LITE_IDX_W-1:0] i_rd_idx,
  output logic [31:0]           o_rd_data,
  output logic                  o_rd_err,
  output logic                  o_wr_err,
  output logic [31:0]           o_ctrl,
  output logic                  o_core_reset
);

  lite_reg_e   w_wr_reg;
  lite_reg_e   w_rd_reg;
  logic [31:0] r_scratch;
  logic [31:0] r_ctrl;
  logic [31:0] r_status;
  logic [31:0] r_shadow;
  logic        r_core_rst;
  logic [63:0] r_cycle;

  assign w_wr_reg = lite_decode(i_wr_idx);
  assign w_rd_reg = lite_decode(i_rd_idx);

  // Only SCRATCH, CTRL and CORE_RST accept writes
  assign o_wr_err = !(w_wr_reg inside {LITE_IDX_SCRATCH, LITE_IDX_CTRL, LITE_IDX_CORE_RST});
  assign o_rd_err = (w_rd_reg == LITE_IDX_NONE);

  // Register state: status sample, counter, shadow snapshot and committed writes
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // which is also why a read and a write on the same edge return the old data.
    if (rst_i) begin
      r_scratch  <= '0;
      r_ctrl     <= CTRL_RST;
      r_status   <= '0;
      r_shadow   <= '0;
      r_core_rst <= 1'b0;
      r_cycle    <= CYCLE_RST;
    end else begin
      r_status <= i_status;
      r_cycle  <= r_cycle + 64'd1;
      if (i_rd_en && (w_rd_reg == LITE_IDX_CYCLE_LO)) r_shadow <= r_cycle[63:32];
      if (i_wr_en) begin
        case (w_wr_reg)
          LITE_IDX_SCRATCH:  r_scratch <= lite_apply_strb(r_scratch, i_wr_data, i_wr_strb);
          LITE_IDX_CTRL:     r_ctrl    <= lite_apply_strb(r_ctrl, i_wr_data, i_wr_strb);
          LITE_IDX_CORE_RST: if (i_wr_strb[0]) r_core_rst <= i_wr_data[0];
          default:           ;
        endcase
      end
    end
  end

  // Read mux on the AR address; unmapped words read as zero
  always_comb begin
    // NOTE: default assigned first so every path drives o_rd_data and no latch is inferred.
    o_rd_data = '0;
    case (w_rd_reg)
      LITE_IDX_ID:       o_rd_data = ID_VALUE;
      LITE_IDX_SCRATCH:  o_rd_data = r_scratch;
      LITE_IDX_CTRL:     o_rd_data = r_ctrl;
      LITE_IDX_STATUS:   o_rd_data = r_status;
      LITE_IDX_CORE_RST: o_rd_data = {31'b0, r_core_rst};
      LITE_IDX_CYCLE_LO: o_rd_data = r_cycle[31:0];
      LITE_IDX_CYCLE_HI: o_rd_data = r_shadow;
      default:           o_rd_data = '0;
    endcase
  end

  assign o_ctrl       = r_ctrl;
  assign o_core_reset = r_core_rst;

endmodule

// File: rtl/fpga_axi_lite_regs.sv
// AXI4-Lite subordinate for the shell control/status register space.
// Holds the AW/W holding registers plus the write and read FSMs; register
// storage lives in fpga_axi_lite_regfile.
// Build option: define FPGA_LITE_SLVERR_EN to answer SLVERR for unmapped
// accesses and writes to read-only registers (default: always OKAY).
module fpga_axi_lite_regs
  import fpga_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = 32'h5A47_0001,
  parameter logic [31:0] CTRL_RST  = 32'h0,
  parameter logic [63:0] CYCLE_RST = 64'h0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  axi_lite_req_t  axi_lite_req_i,
  output axi_lite_resp_t axi_lite_resp_o,
  input  logic [31:0]    status_i,
  output logic [31:0]    ctrl_o,
  output logic           core_reset_o
);

  logic                  r_live;
  wr_state_e             r_wr_state;
  wr_state_e             w_wr_state_nxt;
  rd_state_e             r_rd_state;
  rd_state_e             w_rd_state_nxt;
  logic                  r_aw_full;
  logic [LITE_IDX_W-1:0] r_aw_idx;
  logic                  r_w_full;
  logic [31:0]           r_w_data;
  logic [3:0]            r_w_strb;
  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rdata;

  logic                  w_aw_ready;
  logic                  w_w_ready;
  logic                  w_ar_ready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [LITE_IDX_W-1:0] w_wr_idx;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_strb;
  logic [31:0]           w_rd_data;
  logic                  w_rd_err;
  logic                  w_wr_err;
  logic [1:0]            w_bresp_nxt;
  logic [1:0]            w_rresp_nxt;
  logic                  w_unused;

  // Readies stay low during reset and rise on the first cycle after it
  assign w_aw_ready = r_live && !r_aw_full && (r_wr_state == WR_IDLE);
  assign w_w_ready  = r_live && !r_w_full  && (r_wr_state == WR_IDLE);
  assign w_ar_ready = r_live && (r_rd_state == RD_IDLE);

  assign w_aw_hs = axi_lite_req_i.aw_valid && w_aw_ready;
  assign w_w_hs  = axi_lite_req_i.w_valid  && w_w_ready;
  assign w_ar_hs = axi_lite_req_i.ar_valid && w_ar_ready;

  // A write commits on the edge where both halves are present, held or arriving
  assign w_commit  = (r_wr_state == WR_IDLE) && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
  assign w_wr_idx  = r_aw_full ? r_aw_idx : axi_lite_req_i.aw.addr[12:2];
  assign w_wr_data = r_w_full  ? r_w_data : axi_lite_req_i.w.data;
  assign w_wr_strb = r_w_full  ? r_w_strb : axi_lite_req_i.w.strb;

`ifdef FPGA_LITE_SLVERR_EN
  assign w_bresp_nxt = w_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign w_rresp_nxt = w_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign w_unused = ^{axi_lite_req_i.aw.prot, axi_lite_req_i.aw.addr[1:0],
                      axi_lite_req_i.ar.prot, axi_lite_req_i.ar.addr[1:0]};
`else
  assign w_bresp_nxt = AXI_RESP_OKAY;
  assign w_rresp_nxt = AXI_RESP_OKAY;
  assign w_unused = ^{axi_lite_req_i.aw.prot, axi_lite_req_i.aw.addr[1:0],
                      axi_lite_req_i.ar.prot, axi_lite_req_i.ar.addr[1:0],
                      w_wr_err, w_rd_err};
`endif

  fpga_axi_lite_regfile #(
    .ID_VALUE  (ID_VALUE),
    .CTRL_RST  (CTRL_RST),
    .CYCLE_RST (CYCLE_RST)
  ) u_regfile (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_status     (status_i),
    .i_wr_en      (w_commit),
    .i_wr_idx     (w_wr_idx),
    .i_wr_data    (w_wr_data),
    .i_wr_strb    (w_wr_strb),
    .i_rd_en      (w_ar_hs),
    .i_rd_idx     (axi_lite_req_i.ar.addr[12:2]),
    .o_rd_data    (w_rd_data),
    .o_rd_err     (w_rd_err),
    .o_wr_err     (w_wr_err),
    .o_ctrl       (ctrl_o),
    .o_core_reset (core_reset_o)
  );

  // State registers for both FSMs and the out-of-reset flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_live     <= 1'b0;
      r_wr_state <= WR_IDLE;
      r_rd_state <= RD_IDLE;
    end else begin
      r_live     <= 1'b1;
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Write FSM next state: commit opens the B response, B handshake closes it
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_commit) w_wr_state_nxt = WR_RESP;
      WR_RESP: if (axi_lite_req_i.b_ready) w_wr_state_nxt = WR_IDLE;
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read FSM next state: AR acceptance opens the R response, R handshake closes it
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_ar_hs) w_rd_state_nxt = RD_RESP;
      RD_RESP: if (axi_lite_req_i.r_ready) w_rd_state_nxt = RD_IDLE;
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // AW/W holding registers fill independently and empty together on commit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= axi_lite_req_i.aw.addr[12:2];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= axi_lite_req_i.w.data;
        r_w_strb <= axi_lite_req_i.w.strb;
      end
    end
  end

  // Response payloads are captured once and held until their handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bresp <= AXI_RESP_OKAY;
      r_rresp <= AXI_RESP_OKAY;
      r_rdata <= '0;
    end else begin
      if (w_commit) r_bresp <= w_bresp_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rresp_nxt;
      end
    end
  end

  // Drive the response struct from registered state only
  always_comb begin
    axi_lite_resp_o          = '0;
    axi_lite_resp_o.aw_ready = w_aw_ready;
    axi_lite_resp_o.w_ready  = w_w_ready;
    axi_lite_resp_o.b.resp   = r_bresp;
    axi_lite_resp_o.b_valid  = (r_wr_state == WR_RESP);
    axi_lite_resp_o.ar_ready = w_ar_ready;
    axi_lite_resp_o.r.data   = r_rdata;
    axi_lite_resp_o.r.resp   = r_rresp;
    axi_lite_resp_o.r_valid  = (r_rd_state == RD_RESP);
  end

endmodule

// File: doc/fpga_axi_lite_regs.md
# fpga_axi_lite_regs

AXI4-Lite responder for the FPGA shell's control/status register space on the `axi_lite` bus: 13-bit address, 32-bit data, 4-bit strobe. It terminates host-side AXI-Lite transactions and provides a small register map: ID, scratch, control, status, core reset and a 64-bit cycle counter. It drives static control outputs into the shell and samples status inputs from it. It is the subordinate end of the `axi_lite` request/response pair that shell masters already drive.

## Interface
- `ID_VALUE`, default `32'h5A47_0001`: value returned by the ID register.
- `CTRL_RST`, default `32'h0`: reset value of CTRL.
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: synchronous reset, active-high (fixed: one clock; reset is synchronous and active-high).
- `axi_lite_req_i`, in, `fpga_pkg::axi_lite_req_t`: AW/W/AR channels plus `b_ready`/`r_ready`.
- `axi_lite_resp_o`, out, `fpga_pkg::axi_lite_resp_t`: ready signals plus B/R channels.
- `status_i`, in, 32: sampled into STATUS every cycle.
- `ctrl_o`, out, 32: CTRL register contents.
- `core_reset_o`, out, 1: CORE_RST bit 0.

## Operation
- Decode uses `addr[12:2]`; `addr[1:0]` is ignored. The map:
  - 0x000 ID: read-only.
  - 0x004 SCRATCH: read/write.
  - 0x008 CTRL: read/write.
  - 0x00C STATUS: read-only, registered copy of `status_i`.
  - 0x010 CORE_RST: read/write, bit 0 only; other bits read 0.
  - 0x014 CYCLE_LO and 0x018 CYCLE_HI: read-only.
- Cycle counter: 64 bits, free-running, increments every cycle, wraps from 2^64-1 to 0.
  - A read of CYCLE_LO also snapshots counter bits [63:32] into a shadow register.
  - A read of CYCLE_HI returns the shadow, so a LO-then-HI read pair is coherent.
- Writes are byte-wise under `w.strb`. Writes to read-only registers leave them unchanged.
- Write path, FSM `WR_IDLE -> WR_RESP -> WR_IDLE`:
  - AW and W are captured independently into one-entry holding registers, in either order or in the same cycle.
  - When both holding registers are full, the register update commits on that edge and the FSM enters WR_RESP with `b_valid` high.
  - The FSM returns to WR_IDLE on `b_valid && b_ready`.
  - One outstanding write only.
- Read path, FSM `RD_IDLE -> RD_RESP -> RD_IDLE`:
  - AR is accepted in RD_IDLE; `r.data` is registered on acceptance.
  - The FSM returns to RD_IDLE on `r_valid && r_ready`.
- Read and write paths are fully independent and may be active simultaneously.
- `b.resp`/`r.resp` are OKAY; unmapped addresses read 0 and ignore writes (see Configuration for the alternative).
- `aw.prot`, `ar.prot` and `w` contents beyond data/strb are ignored.

## Timing
- Reset values:
  - `aw_ready`=0, `w_ready`=0, `ar_ready`=0, `b_valid`=0, `r_valid`=0.
  - `r.data`=0; both FSMs idle; holding registers empty.
  - SCRATCH=0, CTRL=`CTRL_RST`, CORE_RST=0, counter=0, shadow=0.
  - From the first cycle after reset: `aw_ready`=1, `w_ready`=1, `ar_ready`=1.
- `aw_ready` is high iff the AW holding register is empty and the FSM is in WR_IDLE. `w_ready` follows the same rule for the W holding register.
- `ar_ready` is high iff the read FSM is in RD_IDLE.
- Latency:
  - Write: AW+W handshake in the same cycle gives `b_valid` on the next cycle.
  - Read: AR handshake gives `r_valid` on the next cycle.
  - Both paths sustain one transaction per 2 cycles when the response ready is held high.
- `b_valid`, `b.resp`, `r_valid`, `r.data` and `r.resp` hold stable until their handshake.
- Read and commit on the same edge to the same register: the read returns the pre-write value.
- `core_reset_o` and `ctrl_o` change on the cycle after the commit edge.
- Reset asserted mid-transaction abandons it. No B/R response is issued afterwards, and registers return to their reset values.

## Configuration
- `FPGA_LITE_SLVERR_EN`:
  - Defined: an access to an unmapped address, or a write to a read-only address, responds SLVERR (`2'b10`). Unmapped reads return data 0.
  - Undefined: every access responds OKAY, with the behaviour described under Operation.

## Structure
- In `fpga_pkg`:
  - Register offset localparams: `LITE_REG_ID` … `LITE_REG_CYCLE_HI`.
  - A `lite_reg_e` enum for the decoded index.
- The request/response types come from the existing `axi_lite` typedefs; no new struct types.
- One sub-module, `fpga_axi_lite_regfile`: register storage, byte-strobe write, read mux, counter and shadow. The top level keeps both FSMs and the holding registers.

## Test plan
- Reset, then read 0x000 → `r_valid` on the cycle after AR, data `32'h5A47_0001`, resp OKAY.
- AW 0x004 at cycle N, W `32'hDEAD_BEEF` strb `4'hF` at cycle N+3 → `b_valid` at N+4; a following read of 0x004 returns `32'hDEAD_BEEF`.
- Write 0x004 with data `32'h1122_3344`, strb `4'b0101`, over `32'hDEAD_BEEF` → readback `32'hDE22_BE44`.
- Write 0x010 data 1 → `core_reset_o`=1 the cycle after commit. Hold `b_ready`=0 for 5 cycles → `aw_ready`=0 and B stable throughout.
- Read 0x014 and then 0x018 with the counter preloaded to `0x0000_0000_FFFF_FFFE` by reset plus waiting → the HI value equals the snapshot taken at the LO read, not the live value after the wrap.
- With `FPGA_LITE_SLVERR_EN`: read 0x100 → data 0, resp SLVERR; write 0x00C → resp SLVERR and STATUS unchanged. Without the macro, both respond OKAY.
